// File: rtl/iop_mem_arbiter.sv
// ---------------------------------------------------------------------------
// iop_mem_arbiter
//
// Purpose:
//   Shares one synchronous single-port byte SRAM between the IOP data port
//   (separate read and write request lines) and a host byte port. Accesses
//   are serialised with round-robin fairness between IOP and host, and each
//   access is stretched by a fixed number of SRAM wait states.
//
// Ports:
//   sysclk, sysrst               clock (rising edge), async active-low reset
//   iop_raddr/iop_read           IOP read request (level, held until iop_rrdy)
//   iop_rdata/iop_rrdy           IOP read data and one-cycle completion pulse
//   iop_waddr/iop_wdata/iop_write IOP write request (level, held until iop_wrdy)
//   iop_wrdy                     IOP write completion pulse
//   host_req/host_we/host_addr/host_wdata  host request (level, held until ack)
//   host_rdata/host_ack          host read data and completion pulse
//   mem_ce/mem_we/mem_addr/mem_wdata       SRAM command (registered)
//   mem_rdata                    SRAM read data, valid one cycle after mem_ce
// ---------------------------------------------------------------------------
module iop_mem_arbiter #(
    parameter int AW          = 24,
    parameter int MEM_AW      = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              sysclk,
    input  logic              sysrst,
    input  logic [AW-1:0]     iop_raddr,
    input  logic              iop_read,
    output logic [7:0]        iop_rdata,
    output logic              iop_rrdy,
    input  logic [AW-1:0]     iop_waddr,
    input  logic [7:0]        iop_wdata,
    input  logic              iop_write,
    output logic              iop_wrdy,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [AW-1:0]     host_addr,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rdata,
    output logic              host_ack,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic       SRC_IOP   = 1'b0;
    localparam logic       SRC_HOST  = 1'b1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    // Address lies inside the physical SRAM when all bits above MEM_AW are zero.
    function automatic logic in_range_f(input logic [AW-1:0] addr);
        return (addr[AW-1:MEM_AW] == {(AW-MEM_AW){1'b0}});
    endfunction

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            src_q, src_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            mem_ce_q, mem_ce_d;
    logic            mem_we_q, mem_we_d;
    logic            iop_rrdy_q, iop_rrdy_d;
    logic            iop_wrdy_q, iop_wrdy_d;
    logic            host_ack_q, host_ack_d;
    logic [7:0]      iop_rdata_q, iop_rdata_d;
    logic [7:0]      host_rdata_q, host_rdata_d;

    logic            iop_pend_s;
    logic            grant_iop_s;
    logic            sel_src_s;
    logic            sel_we_s;
    logic [AW-1:0]   sel_addr_s;
    logic [7:0]      sel_wdata_s;
    logic            sel_in_range_s;
    logic [7:0]      rdata_eff_s;
    logic            go_done_s;

    // Request selection: when both sides are pending the side not served last wins.
    // An IOP write takes precedence over a simultaneous IOP read.
    assign iop_pend_s     = iop_read | iop_write;
    assign grant_iop_s    = iop_pend_s & (~host_req | (last_grant_q == SRC_HOST));
    assign sel_src_s      = grant_iop_s ? SRC_IOP : SRC_HOST;
    assign sel_we_s       = grant_iop_s ? iop_write : host_we;
    assign sel_addr_s     = grant_iop_s ? (iop_write ? iop_waddr : iop_raddr) : host_addr;
    assign sel_wdata_s    = grant_iop_s ? iop_wdata : host_wdata;
    assign sel_in_range_s = in_range_f(sel_addr_s);

    // Out-of-range reads never touched the SRAM and return all ones.
    assign rdata_eff_s    = in_range_f(addr_q) ? mem_rdata : 8'hFF;

    // Next-state and registered-output computation for the access sequencer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        src_d        = src_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        mem_ce_d     = 1'b0;
        mem_we_d     = 1'b0;
        iop_rdata_d  = iop_rdata_q;
        host_rdata_d = host_rdata_q;
        go_done_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iop_pend_s || host_req) begin
                    state_d      = ST_ACCESS;
                    last_grant_d = sel_src_s;
                    src_d        = sel_src_s;
                    we_d         = sel_we_s;
                    addr_d       = sel_addr_s;
                    wdata_d      = sel_wdata_s;
                    mem_ce_d     = sel_in_range_s;
                    mem_we_d     = sel_in_range_s & sel_we_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (WAIT_INIT == 4'd0) begin
                    state_d   = ST_DONE;
                    go_done_s = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_INIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d   = ST_DONE;
                    cnt_d     = 4'd0;
                    go_done_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (!we_q && (src_q == SRC_IOP)) begin
                    iop_rdata_d = rdata_eff_s;
                end else if (!we_q) begin
                    host_rdata_d = rdata_eff_s;
                end else begin
                    iop_rdata_d  = iop_rdata_q;
                    host_rdata_d = host_rdata_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Completion pulses are registered so they line up with the DONE cycle.
        iop_rrdy_d = go_done_s & (src_q == SRC_IOP) & ~we_q;
        iop_wrdy_d = go_done_s & (src_q == SRC_IOP) & we_q;
        host_ack_d = go_done_s & (src_q == SRC_HOST);
    end

    // State and output registers; asynchronous reset clears everything.
    always_ff @(posedge sysclk or negedge sysrst) begin
        if (!sysrst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= SRC_HOST;
            src_q        <= SRC_IOP;
            we_q         <= 1'b0;
            addr_q       <= {AW{1'b0}};
            wdata_q      <= 8'h00;
            cnt_q        <= 4'd0;
            mem_ce_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            iop_rrdy_q   <= 1'b0;
            iop_wrdy_q   <= 1'b0;
            host_ack_q   <= 1'b0;
            iop_rdata_q  <= 8'h00;
            host_rdata_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            src_q        <= src_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            mem_ce_q     <= mem_ce_d;
            mem_we_q     <= mem_we_d;
            iop_rrdy_q   <= iop_rrdy_d;
            iop_wrdy_q   <= iop_wrdy_d;
            host_ack_q   <= host_ack_d;
            iop_rdata_q  <= iop_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    // The SRAM delivers read data in the DONE cycle itself, so during the
    // ready pulse the data is forwarded; the register holds it afterwards.
    assign iop_rdata  = iop_rrdy_q ? rdata_eff_s : iop_rdata_q;
    assign host_rdata = (host_ack_q && !we_q) ? rdata_eff_s : host_rdata_q;
    assign iop_rrdy   = iop_rrdy_q;
    assign iop_wrdy   = iop_wrdy_q;
    assign host_ack   = host_ack_q;
    assign mem_ce     = mem_ce_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = addr_q[MEM_AW-1:0];
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_iop_mem_arbiter.sv
module tb_iop_mem_arbiter;
    localparam int AW = 24;
    localparam int MAW = 12;
    localparam int W = 3;

    logic sysclk = 1'b0;
    logic sysrst;
    logic [AW-1:0] iop_raddr, iop_waddr, host_addr;
    logic iop_read, iop_write, host_req, host_we;
    logic [7:0] iop_wdata, host_wdata, iop_rdata, host_rdata, mem_wdata, mem_rdata;
    logic iop_rrdy, iop_wrdy, host_ack, mem_ce, mem_we;
    logic [MAW-1:0] mem_addr;

    iop_mem_arbiter #(.AW(AW), .MEM_AW(MAW), .WAIT_CYCLES(W)) dut (
        .sysclk(sysclk), .sysrst(sysrst),
        .iop_raddr(iop_raddr), .iop_read(iop_read), .iop_rdata(iop_rdata), .iop_rrdy(iop_rrdy),
        .iop_waddr(iop_waddr), .iop_wdata(iop_wdata), .iop_write(iop_write), .iop_wrdy(iop_wrdy),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_ack(host_ack),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    function automatic logic [7:0] init_pat(input logic [MAW-1:0] a);
        if (a == 12'h010) return 8'h5A;
        else return 8'(32'(a) * 37 + 11);
    endfunction

    // SRAM model: unwritten locations read back their initial pattern.
    logic [7:0] sram [0:4095];
    bit         sram_v [0:4095];
    logic [7:0] sram_rdata = 8'h00;
    assign mem_rdata = sram_rdata;
    always @(posedge sysclk) begin
        if (mem_ce) begin
            if (mem_we) begin
                sram[mem_addr]   <= mem_wdata;
                sram_v[mem_addr] <= 1'b1;
            end else begin
                sram_rdata <= sram_v[mem_addr] ? sram[mem_addr] : init_pat(mem_addr);
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: one transaction at a time, 3+W cycles per access.
    logic [7:0] ref_mem [0:4095];
    logic m_last;
    bit   m_busy;
    int   m_ce_cyc, m_done_cyc, m_free_cyc;
    logic m_src, m_we, m_inr;
    logic [MAW-1:0] m_maddr;
    logic [7:0] m_wdata, m_rdata, e_iop_rdata, e_host_rdata;

    typedef struct { bit rd; bit wr; logic [23:0] raddr; logic [23:0] waddr; logic [7:0] wdata; int gap; } iop_op_t;
    typedef struct { bit we; logic [23:0] addr; logic [7:0] wdata; int gap; } host_op_t;
    iop_op_t  iop_q[$];
    host_op_t host_q[$];
    iop_op_t  iop_cur;
    host_op_t host_cur;
    bit iop_act, host_act, iop_rd_left, iop_wr_left;
    int iop_gap, host_gap;

    task automatic push_iop(input bit rd, input bit wr, input logic [23:0] ra, input logic [23:0] wa,
                            input logic [7:0] wd, input int gap);
        iop_op_t op;
        op.rd = rd; op.wr = wr; op.raddr = ra; op.waddr = wa; op.wdata = wd; op.gap = gap;
        iop_q.push_back(op);
    endtask

    task automatic push_host(input bit we, input logic [23:0] a, input logic [7:0] wd, input int gap);
        host_op_t op;
        op.we = we; op.addr = a; op.wdata = wd; op.gap = gap;
        host_q.push_back(op);
    endtask

    function automatic logic [23:0] rand_addr();
        logic [23:0] a;
        if ($urandom_range(0, 7) == 0) a = {12'($urandom_range(1, 4095)), 12'($urandom)};
        else a = {20'h00001, 4'($urandom)};
        return a;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rrdy"}, iop_rrdy, 0);
        chk({tag, "_wrdy"}, iop_wrdy, 0);
        chk({tag, "_ack"}, host_ack, 0);
        chk({tag, "_ce"}, mem_ce, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_iop_rdata"}, iop_rdata, 0);
        chk({tag, "_host_rdata"}, host_rdata, 0);
    endtask

    // One cycle: check outputs against the model, retire, drive, grant.
    task automatic tick();
        bit pulse_now, e_rrdy, e_wrdy, e_ack, e_ce, gi;
        logic [23:0] a;
        @(negedge sysclk);
        pulse_now = m_busy && (cyc == m_done_cyc);
        e_rrdy = pulse_now && (m_src == 1'b0) && !m_we;
        e_wrdy = pulse_now && (m_src == 1'b0) && m_we;
        e_ack  = pulse_now && (m_src == 1'b1);
        if (e_rrdy) e_iop_rdata = m_rdata;
        if (e_ack && !m_we) e_host_rdata = m_rdata;
        chk("iop_rrdy", iop_rrdy, e_rrdy);
        chk("iop_wrdy", iop_wrdy, e_wrdy);
        chk("host_ack", host_ack, e_ack);
        chk("iop_rdata", iop_rdata, e_iop_rdata);
        chk("host_rdata", host_rdata, e_host_rdata);
        e_ce = m_busy && (cyc == m_ce_cyc) && m_inr;
        chk("mem_ce", mem_ce, e_ce);
        if (e_ce) begin
            chk("mem_we", mem_we, m_we);
            chk("mem_addr", mem_addr, m_maddr);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
        if (pulse_now) begin
            m_busy = 1'b0;
            if (m_src == 1'b0) begin
                if (m_we) iop_wr_left = 1'b0; else iop_rd_left = 1'b0;
                if (!iop_rd_left && !iop_wr_left) begin iop_act = 1'b0; iop_gap = iop_cur.gap; end
            end else begin
                host_act = 1'b0; host_gap = host_cur.gap;
            end
        end
        if (!iop_act) begin
            if (iop_gap > 0) iop_gap--;
            else if (iop_q.size() > 0) begin
                iop_cur = iop_q.pop_front(); iop_act = 1'b1;
                iop_rd_left = iop_cur.rd; iop_wr_left = iop_cur.wr;
            end
        end
        if (!host_act) begin
            if (host_gap > 0) host_gap--;
            else if (host_q.size() > 0) begin host_cur = host_q.pop_front(); host_act = 1'b1; end
        end
        iop_read = iop_act && iop_rd_left;  iop_write = iop_act && iop_wr_left;
        iop_raddr = iop_cur.raddr; iop_waddr = iop_cur.waddr; iop_wdata = iop_cur.wdata;
        host_req = host_act; host_we = host_cur.we; host_addr = host_cur.addr; host_wdata = host_cur.wdata;
        if (!m_busy && cyc >= m_free_cyc && (iop_read || iop_write || host_req)) begin
            gi = (iop_read || iop_write) && (!host_req || m_last == 1'b1);
            m_src = gi ? 1'b0 : 1'b1;
            m_we = gi ? iop_write : host_we;
            a = gi ? (iop_write ? iop_waddr : iop_raddr) : host_addr;
            m_wdata = gi ? iop_wdata : host_wdata;
            m_inr = (a[23:12] == 12'h000);
            m_maddr = a[11:0];
            m_last = m_src;
            m_busy = 1'b1;
            m_ce_cyc = cyc + 1; m_done_cyc = cyc + 2 + W; m_free_cyc = cyc + 3 + W;
            if (m_we) begin
                if (m_inr) ref_mem[m_maddr] = m_wdata;
            end else begin
                m_rdata = m_inr ? ref_mem[m_maddr] : 8'hFF;
            end
        end
    endtask

    task automatic run(input int budget);
        int n;
        n = 0;
        while ((iop_act || host_act || iop_q.size() > 0 || host_q.size() > 0 || m_busy) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_in_budget", (n < budget), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        sysrst = 1'b0;
        iop_read = 0; iop_write = 0; host_req = 0; host_we = 0;
        iop_raddr = 0; iop_waddr = 0; iop_wdata = 0; host_addr = 0; host_wdata = 0;
        iop_cur = '{rd:0, wr:0, raddr:0, waddr:0, wdata:0, gap:0};
        host_cur = '{we:0, addr:0, wdata:0, gap:0};
        iop_act = 0; host_act = 0; iop_rd_left = 0; iop_wr_left = 0; iop_gap = 0; host_gap = 0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_pat(12'(i));
        m_last = 1'b1; m_busy = 0; m_free_cyc = 0; m_ce_cyc = -1; m_done_cyc = -1;
        m_src = 0; m_we = 0; m_inr = 0; m_maddr = 0; m_wdata = 0; m_rdata = 0;
        e_iop_rdata = 8'h00; e_host_rdata = 8'h00;

        repeat (3) begin @(negedge sysclk); chk_all_zero("reset"); end
        sysrst = 1'b1; m_free_cyc = cyc;

        // Simultaneous IOP write and host read of the same address after reset.
        push_iop(0, 1, 24'h0, 24'h000040, 8'h99, 0);
        push_host(0, 24'h000040, 8'h00, 0);
        run(200);

        // Single IOP read of a preloaded location.
        push_iop(1, 0, 24'h000010, 24'h0, 8'h00, 0);
        run(200);

        // IOP read and write raised together on the same address.
        push_iop(1, 1, 24'h000020, 24'h000020, 8'hC3, 0);
        run(200);

        // Continuous traffic from both sides: strict alternation.
        for (int i = 0; i < 10; i++) begin
            n = $urandom_range(0, 1);
            push_iop(n == 0, n == 1, {20'h00001, 4'($urandom)}, {20'h00001, 4'($urandom)}, 8'($urandom), 0);
            push_host($urandom_range(0, 1) == 1, {20'h00001, 4'($urandom)}, 8'($urandom), 0);
        end
        run(1000);

        // Random mix with gaps, dual IOP requests and out-of-range addresses.
        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 2);
            push_iop(n != 1, n != 0, rand_addr(), rand_addr(), 8'($urandom), $urandom_range(0, 4));
            push_host($urandom_range(0, 1) == 1, rand_addr(), 8'($urandom), $urandom_range(0, 4));
        end
        run(3000);

        // Out-of-range host read: no SRAM cycle, data all ones.
        push_host(0, 24'h010000, 8'h00, 0);
        run(200);

        // Reset asserted while the access is in its wait states.
        push_host(0, 24'h000123, 8'h00, 0);
        n = 0;
        while (!(m_busy && cyc == m_ce_cyc + 1) && n < 50) begin tick(); n++; end
        chk("reach_wait", (n < 50), 1);
        #2 sysrst = 1'b0;
        #1 chk_all_zero("rst_async");
        m_busy = 0; m_last = 1'b1; e_iop_rdata = 8'h00; e_host_rdata = 8'h00;
        iop_q.delete(); host_q.delete();
        iop_act = 0; host_act = 0; iop_rd_left = 0; iop_wr_left = 0; iop_gap = 0; host_gap = 0;
        iop_read = 0; iop_write = 0; host_req = 0;
        repeat (2) begin @(negedge sysclk); chk_all_zero("rst_hold"); end
        sysrst = 1'b1; m_free_cyc = cyc;

        // Restart from IDLE with round-robin pointer back at host.
        push_iop(1, 0, 24'h000010, 24'h0, 8'h00, 0);
        push_host(1, 24'h000011, 8'h6E, 0);
        push_host(0, 24'h000011, 8'h00, 0);
        run(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
